// File: rtl/editor_hora.sv
// editor_hora: BCD time-of-day field editor with cursor, wrap-around edits and auto-repeat
module editor_hora #(
  parameter int REP_DELAY  = 25_000_000,
  parameter int REP_PERIOD = 10_000_000
) (
  input  logic       clk,
  input  logic       resetM,
  input  logic [3:0] IN_bot_hora,
  input  logic       cargar,
  input  logic [7:0] hora_in,
  input  logic [7:0] min_in,
  input  logic [7:0] seg_in,
  output logic [7:0] hora_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] seg_bcd,
  output logic [1:0] cursor,
  output logic       escribir
);
  localparam int CW = $clog2((REP_DELAY > REP_PERIOD ? REP_DELAY : REP_PERIOD) + 1);
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] btn_q, press;
  logic changed, act_up, act_dn, act_r, act_l, rep_up, rep_up_n, rep_step, up, dn;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] mx);
    return v == mx ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'h01;
  endfunction
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] mx);
    return v == 8'h00 ? mx : v[3:0] == 4'd0 ? {v[7:4] - 4'd1, 4'd9} : v - 8'h01;
  endfunction
  function automatic logic [7:0] bcd_chk(input logic [7:0] v, input logic [7:0] mx);
    return (v[3:0] <= 4'd9 && v[7:4] <= 4'd9 && v <= mx) ? v : 8'h00;
  endfunction
  function automatic logic [7:0] edit(input logic [7:0] v, input logic [7:0] mx, input logic sel, input logic u, input logic d);
    return !sel ? v : u ? bcd_inc(v, mx) : d ? bcd_dec(v, mx) : v;
  endfunction
  // press detection and fixed priority SUMAR > RESTAR > DERECHA > IZQUIERDA
  always_comb begin
    press   = IN_bot_hora & ~btn_q;
    changed = IN_bot_hora != btn_q;
    act_up  = press[3];
    act_dn  = press[2] & ~press[3];
    act_r   = press[1] & ~|press[3:2];
    act_l   = press[0] & ~|press[3:1];
  end
  // repeat state register, counter and remembered direction
  always_ff @(posedge clk) begin
    if (resetM) begin
      state  <= IDLE;
      cnt    <= '0;
      rep_up <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rep_up <= rep_up_n;
    end
  end
  // repeat next-state: a new SUMAR/RESTAR press restarts the delay, any other change stops it
  always_comb begin
    state_n  = state;
    cnt_n    = state == IDLE ? '0 : cnt + CW'(1);
    rep_up_n = rep_up;
    if (cargar) state_n = IDLE;
    else if (act_up | act_dn) begin
      state_n  = DELAY;
      cnt_n    = CW'(1);
      rep_up_n = act_up;
    end else if (changed) state_n = IDLE;
    else if (rep_step) begin
      state_n = REPEAT;
      cnt_n   = CW'(1);
    end
  end
  // repeat output: step when the held button reaches the delay or period boundary
  always_comb begin
    rep_step = !changed && ((state == DELAY && cnt == CW'(REP_DELAY)) || (state == REPEAT && cnt == CW'(REP_PERIOD)));
    up       = act_up | (rep_step & rep_up);
    dn       = act_dn | (rep_step & ~rep_up);
  end
  // field, cursor and write-strobe registers; external load wins over buttons
  always_ff @(posedge clk) begin
    if (resetM) begin
      btn_q    <= 4'd0;
      hora_bcd <= 8'h00;
      min_bcd  <= 8'h00;
      seg_bcd  <= 8'h00;
      cursor   <= 2'd0;
      escribir <= 1'b0;
    end else begin
      btn_q <= IN_bot_hora;
      if (cargar) begin
        hora_bcd <= bcd_chk(hora_in, 8'h23);
        min_bcd  <= bcd_chk(min_in, 8'h59);
        seg_bcd  <= bcd_chk(seg_in, 8'h59);
        escribir <= 1'b0;
      end else begin
        hora_bcd <= edit(hora_bcd, 8'h23, cursor == 2'd0, up, dn);
        min_bcd  <= edit(min_bcd, 8'h59, cursor == 2'd1, up, dn);
        seg_bcd  <= edit(seg_bcd, 8'h59, cursor == 2'd2, up, dn);
        escribir <= up | dn;
        cursor   <= act_r ? (cursor == 2'd2 ? 2'd0 : cursor + 2'd1) :
                    act_l ? (cursor == 2'd0 ? 2'd2 : cursor - 2'd1) : cursor;
      end
    end
  end
endmodule

// File: tb/tb_editor_hora.sv
// tb_editor_hora: directed self-checking bench for editor_hora
module tb_editor_hora;
  logic       clk = 1'b0;
  logic       resetM = 1'b1;
  logic [3:0] btn = 4'd0;
  logic       cargar = 1'b0;
  logic [7:0] hora_in = 8'h00, min_in = 8'h00, seg_in = 8'h00;
  logic [7:0] hora_bcd, min_bcd, seg_bcd;
  logic [1:0] cursor;
  logic       escribir;
  int pass = 0, total = 0, wcnt = 0;
  editor_hora #(.REP_DELAY(8), .REP_PERIOD(4)) dut (
    .clk(clk), .resetM(resetM), .IN_bot_hora(btn), .cargar(cargar),
    .hora_in(hora_in), .min_in(min_in), .seg_in(seg_in),
    .hora_bcd(hora_bcd), .min_bcd(min_bcd), .seg_bcd(seg_bcd),
    .cursor(cursor), .escribir(escribir)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (escribir) wcnt++;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  initial begin
    tick();
    tick();
    resetM = 1'b0;
    chk("rst_hora", hora_bcd, 8'h00);
    chk("rst_min", min_bcd, 8'h00);
    chk("rst_seg", seg_bcd, 8'h00);
    chk("rst_cursor", cursor, 0);
    chk("rst_escribir", escribir, 0);
    wcnt = 0;
    for (int i = 0; i < 3; i++) begin
      btn = 4'b1000; tick(); tick();
      btn = 4'b0000; tick(); tick();
    end
    chk("sumar3_hora", hora_bcd, 8'h03);
    chk("sumar3_pulses", wcnt, 3);
    for (int i = 0; i < 3; i++) begin
      btn = 4'b0100; tick();
      btn = 4'b0000; tick();
    end
    chk("restar_to_00", hora_bcd, 8'h00);
    btn = 4'b0100; tick();
    chk("restar_wrap", hora_bcd, 8'h23);
    chk("restar_escribir", escribir, 1);
    btn = 4'b0000; tick();
    chk("escribir_one_cycle", escribir, 0);
    wcnt = 0;
    btn = 4'b0010; tick();
    btn = 4'b0000; tick();
    chk("derecha_cursor1", cursor, 1);
    chk("derecha_no_write", wcnt, 0);
    for (int i = 0; i < 60; i++) begin
      btn = 4'b1000; tick();
      if (i == 8) chk("min_09", min_bcd, 8'h09);
      if (i == 9) chk("min_10", min_bcd, 8'h10);
      if (i == 58) chk("min_59", min_bcd, 8'h59);
      if (i == 59) chk("min_wrap_00", min_bcd, 8'h00);
      btn = 4'b0000; tick();
    end
    chk("hora_kept_23", hora_bcd, 8'h23);
    wcnt = 0;
    btn = 4'b0001; tick(); btn = 4'b0000; tick();
    chk("izq_1_to_0", cursor, 0);
    btn = 4'b0001; tick(); btn = 4'b0000; tick();
    chk("izq_0_to_2", cursor, 2);
    btn = 4'b0010; tick(); btn = 4'b0000; tick();
    chk("der_2_to_0", cursor, 0);
    chk("cursor_no_write", wcnt, 0);
    btn = 4'b0001; tick(); btn = 4'b0000; tick();
    chk("cursor_seg", cursor, 2);
    btn = 4'b1000;
    for (int j = 0; j < 20; j++) begin
      tick();
      chk($sformatf("hold_seg_%0d", j), seg_bcd, 1 + (j >= 8) + (j >= 12) + (j >= 16));
    end
    btn = 4'b0000; tick();
    chk("release_seg", seg_bcd, 8'h04);
    repeat (6) tick();
    chk("release_stays", seg_bcd, 8'h04);
    btn = 4'b1010; tick();
    chk("simul_seg", seg_bcd, 8'h05);
    chk("simul_cursor", cursor, 2);
    btn = 4'b0000; tick();
    cargar = 1'b1; hora_in = 8'h25; min_in = 8'h4A; seg_in = 8'h30; btn = 4'b1000; tick();
    chk("load_hora_bad", hora_bcd, 8'h00);
    chk("load_min_bad", min_bcd, 8'h00);
    chk("load_seg", seg_bcd, 8'h30);
    chk("load_escribir", escribir, 0);
    chk("load_cursor", cursor, 2);
    hora_in = 8'h19; min_in = 8'h45; seg_in = 8'h59; btn = 4'b0000; tick();
    chk("load_hora_ok", hora_bcd, 8'h19);
    chk("load_min_ok", min_bcd, 8'h45);
    chk("load_seg_ok", seg_bcd, 8'h59);
    hora_in = 8'h15; min_in = 8'h00; seg_in = 8'h00; tick();
    cargar = 1'b0;
    btn = 4'b0010; tick(); btn = 4'b0000; tick();
    chk("cursor_hora", cursor, 0);
    btn = 4'b1000; tick();
    chk("rep_first", hora_bcd, 8'h16);
    repeat (8) tick();
    chk("rep_enter", hora_bcd, 8'h17);
    repeat (2) tick();
    chk("rep_mid", hora_bcd, 8'h17);
    resetM = 1'b1; btn = 4'b0000; tick();
    chk("mid_rst_hora", hora_bcd, 8'h00);
    chk("mid_rst_cursor", cursor, 0);
    resetM = 1'b0; wcnt = 0;
    repeat (6) tick();
    chk("post_rst_hora", hora_bcd, 8'h00);
    chk("post_rst_writes", wcnt, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
